// File: rtl/linreg_pkg.sv
// Shared definitions for the linear-regression prediction path: default widths,
// predictor FSM states and the output saturation helper.
package linreg_pkg;

  localparam int FRAC  = 10;  // fraction bits of b1
  localparam int X_W   = 20;  // sample width, unsigned
  localparam int B1_W  = 56;  // slope width, unsigned
  localparam int B0_W  = 84;  // intercept width, signed
  localparam int OUT_W = 64;  // prediction width, signed
  localparam int CNT_W = 32;  // delivered-sample counter width
  localparam int SUM_W = B0_W + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pred_state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [OUT_W-1:0] y;
  } pred_t;

  // Clamp the wide intercept+product sum into the signed output range.
  function automatic pred_t sat_to_out(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    pred_t                   r;
    hi = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (sum > hi) begin
      r.sat = 1'b1;
      r.y   = hi[OUT_W-1:0];
    end else if (sum < lo) begin
      r.sat = 1'b1;
      r.y   = lo[OUT_W-1:0];
    end else begin
      r.sat = 1'b0;
      r.y   = sum[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/linreg_pred_stage.sv
// One pipeline register slice: valid bit plus payload, both frozen while
// advance is low so a stalled sink never loses or duplicates a sample.
module linreg_pred_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Next-state: load on advance; payload only captured for real samples.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    if (advance) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // Slice register; payload is reset too so outputs read 0 straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/linreg_predictor.sv
// Streaming linear-regression predictor: y_hat = b0 + ((b1*x) >> FRAC),
// saturated to OUT_W bits, two pipeline stages, valid/ready on both sides.
// Coefficient loads are deferred (DRAIN) until no sample is in flight, so every
// sample is evaluated with one consistent coefficient pair.
// Optional residual path: define LINREG_RESIDUAL_EN to add in_y/out_res/out_abs_sum.
module linreg_predictor
  import linreg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_load,
  input  logic signed [B0_W-1:0]  coef_b0,
  input  logic [B1_W-1:0]         coef_b1,
  output logic                    coef_busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X_W-1:0]          in_x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_y,
  output logic                    out_sat,
  output logic [CNT_W-1:0]        out_count
`ifdef LINREG_RESIDUAL_EN
  ,
  input  logic [X_W-1:0]            in_y,
  output logic signed [OUT_W:0]     out_res,
  output logic [OUT_W+CNT_W-1:0]    out_abs_sum
`endif
);

  localparam int PROD_W  = B1_W + X_W;
  localparam int SHIFT_W = PROD_W - FRAC;
  localparam int ACC_W   = OUT_W + CNT_W;
`ifdef LINREG_RESIDUAL_EN
  localparam int S1_W = PROD_W + X_W;
  localparam int S2_W = OUT_W + 1 + X_W;
`else
  localparam int S1_W = PROD_W;
  localparam int S2_W = OUT_W + 1;
`endif

  pred_state_t            state_d, state_q;
  logic signed [B0_W-1:0] b0_d, b0_q, sh_b0_d, sh_b0_q;
  logic [B1_W-1:0]        b1_d, b1_q, sh_b1_d, sh_b1_q;
  logic [CNT_W-1:0]       count_d, count_q;
  logic                   apply;

  logic                   advance, accept, deliver, pipe_busy;
  logic                   s1_valid, s2_valid;
  logic [S1_W-1:0]        s1_in, s1_data;
  logic [S2_W-1:0]        s2_in, s2_data;
  logic [PROD_W-1:0]      prod, s1_prod;
  logic signed [SUM_W-1:0] sum;
  pred_t                  pred, out_pred;

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = (state_q == RUN) && advance;
  assign accept    = in_valid && in_ready;
  assign deliver   = s2_valid && out_ready;
  // A sample accepted this cycle counts as in flight so it keeps the old coefficients.
  assign pipe_busy = s1_valid || s2_valid || accept;

  // Stage 1 payload: full-precision unsigned product.
  assign prod = {{X_W{1'b0}}, b1_q} * {{B1_W{1'b0}}, in_x};
`ifdef LINREG_RESIDUAL_EN
  assign s1_in = {in_y, prod};
`else
  assign s1_in = prod;
`endif

  linreg_pred_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .in_valid  (accept),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_data  (s1_data)
  );

  // Stage 2 payload: intercept plus truncated product, clamped.
  assign s1_prod = s1_data[PROD_W-1:0];
  assign sum     = $signed({b0_q[B0_W-1], b0_q})
                 + $signed({{(SUM_W-SHIFT_W){1'b0}}, s1_prod[PROD_W-1:FRAC]});
  assign pred    = sat_to_out(sum);
`ifdef LINREG_RESIDUAL_EN
  assign s2_in = {s1_data[S1_W-1:PROD_W], pred};
`else
  assign s2_in = pred;
`endif

  linreg_pred_stage #(.W(S2_W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .advance   (advance),
    .in_valid  (s1_valid),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_data  (s2_data)
  );

  assign out_pred  = s2_data[OUT_W:0];
  assign out_valid = s2_valid;
  assign out_y     = out_pred.y;
  assign out_sat   = out_pred.sat;
  assign coef_busy = (state_q == DRAIN);
  assign out_count = count_q;

  // Coefficient FSM: apply directly when nothing is in flight, else shadow and drain.
  always_comb begin
    state_d = state_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    sh_b0_d = sh_b0_q;
    sh_b1_d = sh_b1_q;
    apply   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (coef_load) begin
          b0_d    = coef_b0;
          b1_d    = coef_b1;
          apply   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (coef_load) begin
          if (pipe_busy) begin
            sh_b0_d = coef_b0;
            sh_b1_d = coef_b1;
            state_d = DRAIN;
          end else begin
            b0_d  = coef_b0;
            b1_d  = coef_b1;
            apply = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A fresh load overrides the shadow, even on the apply cycle.
        if (coef_load) begin
          sh_b0_d = coef_b0;
          sh_b1_d = coef_b1;
        end
        if (!s1_valid && !s2_valid) begin
          b0_d    = sh_b0_d;
          b1_d    = sh_b1_d;
          apply   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Delivered-sample counter, cleared whenever new coefficients take effect.
  always_comb begin
    count_d = count_q;
    if (apply)        count_d = '0;
    else if (deliver) count_d = count_q + 1'b1;
  end

  // State, live/shadow coefficient and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      b0_q    <= '0;
      b1_q    <= '0;
      sh_b0_q <= '0;
      sh_b1_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      sh_b0_q <= sh_b0_d;
      sh_b1_q <= sh_b1_d;
      count_q <= count_d;
    end
  end

`ifdef LINREG_RESIDUAL_EN
  logic [X_W-1:0]        out_yin;
  logic signed [OUT_W:0] res;
  logic [OUT_W:0]        res_abs;
  logic [ACC_W:0]        acc_sum;
  logic [ACC_W-1:0]      abs_sum_d, abs_sum_q;

  // Residual uses the clamped prediction that is actually presented.
  assign out_yin = s2_data[S2_W-1:OUT_W+1];
  assign res     = $signed({{(OUT_W+1-X_W){1'b0}}, out_yin})
                 - $signed({out_pred.y[OUT_W-1], out_pred.y});
  assign res_abs = res[OUT_W] ? $unsigned(-res) : $unsigned(res);
  assign acc_sum = {1'b0, abs_sum_q} + {{(ACC_W-OUT_W){1'b0}}, res_abs};

  // Saturating accumulator of |residual| over delivered predictions.
  always_comb begin
    abs_sum_d = abs_sum_q;
    if (apply)        abs_sum_d = '0;
    else if (deliver) abs_sum_d = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abs_sum_q <= '0;
    else     abs_sum_q <= abs_sum_d;
  end

  assign out_res     = res;
  assign out_abs_sum = abs_sum_q;
`endif

endmodule

// File: tb/tb_linreg_predictor.sv
// Self-checking bench for linreg_predictor: directed scenarios plus a random
// phase, all predictions compared against an arithmetic reference model.
module tb_linreg_predictor;
  import linreg_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    coef_load;
  logic signed [B0_W-1:0]  coef_b0;
  logic [B1_W-1:0]         coef_b1;
  logic                    coef_busy;
  logic                    in_valid;
  logic                    in_ready;
  logic [X_W-1:0]          in_x;
  logic [X_W-1:0]          in_y_s;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_y;
  logic                    out_sat;
  logic [CNT_W-1:0]        out_count;
`ifdef LINREG_RESIDUAL_EN
  logic signed [OUT_W:0]         out_res;
  logic [OUT_W+CNT_W-1:0]        out_abs_sum;
`endif

  linreg_predictor dut (
    .clk       (clk),
    .rst       (rst),
    .coef_load (coef_load),
    .coef_b0   (coef_b0),
    .coef_b1   (coef_b1),
    .coef_busy (coef_busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_sat   (out_sat),
    .out_count (out_count)
`ifdef LINREG_RESIDUAL_EN
    ,
    .in_y        (in_y_s),
    .out_res     (out_res),
    .out_abs_sum (out_abs_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OUT_W-1:0] y;
    logic                    sat;
    logic signed [OUT_W:0]   res;
  } exp_t;

  exp_t                   exp_q[$];
  logic signed [B0_W-1:0] mb0;
  logic [B1_W-1:0]        mb1;
  int                     mcount;
  logic [OUT_W+CNT_W-1:0] masum;
  bit                     pending;
  bit                     have_coef;
  bit                     last_acc;
  int                     delivered;
  int                     errors = 0;
  int                     checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide arithmetic, clamp to the signed output range.
  function automatic exp_t model(input logic signed [B0_W-1:0] b0, input logic [B1_W-1:0] b1,
                                 input logic [X_W-1:0] x, input logic [X_W-1:0] yin);
    logic signed [127:0] s, hi, lo, r;
    logic [127:0]        p;
    exp_t                e;
    hi = (128'sd1 <<< (OUT_W-1)) - 128'sd1;
    lo = -(128'sd1 <<< (OUT_W-1));
    p  = b1;
    p  = (p * x) >> FRAC;
    s  = b0;
    s  = s + $signed(p);
    if (s > hi)      begin e.y = hi[OUT_W-1:0]; e.sat = 1'b1; end
    else if (s < lo) begin e.y = lo[OUT_W-1:0]; e.sat = 1'b1; end
    else             begin e.y = s[OUT_W-1:0];  e.sat = 1'b0; end
    r     = $signed({{(128-X_W){1'b0}}, yin}) - e.y;
    e.res = r[OUT_W:0];
    return e;
  endfunction

  // One clock: check outputs against the model, track handshakes, advance to next negedge.
  task automatic cycle();
    exp_t                  e;
    logic signed [127:0]   a;
    logic [OUT_W+CNT_W:0]  t;
    #1;
    check("out_count", out_count, 128'(mcount));
    check("coef_busy", coef_busy, 128'(pending));
    check("in_ready", in_ready, 128'(have_coef && !pending && (!out_valid || out_ready)));
`ifdef LINREG_RESIDUAL_EN
    check("out_abs_sum", out_abs_sum, masum);
`endif
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        e = exp_q[0];
        check("out_y", out_y, e.y);
        check("out_sat", out_sat, e.sat);
`ifdef LINREG_RESIDUAL_EN
        check("out_res", out_res, e.res);
`endif
        if (out_ready) begin
          void'(exp_q.pop_front());
          mcount++;
          delivered++;
          a = e.res;
          if (a < 0) a = -a;
          t = {1'b0, masum} + (OUT_W+CNT_W+1)'(a);
          masum = t[OUT_W+CNT_W] ? '1 : t[OUT_W+CNT_W-1:0];
        end
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) exp_q.push_back(model(mb0, mb1, in_x, in_y_s));
    if (coef_load) begin
      mb0 = coef_b0; mb1 = coef_b1; pending = 1'b1; have_coef = 1'b1;
    end
    if (pending && exp_q.size() == 0 && !(out_valid && out_ready)) begin
      pending = 1'b0; mcount = 0; masum = '0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic signed [B0_W-1:0] b0, input logic [B1_W-1:0] b1);
    coef_load = 1'b1; coef_b0 = b0; coef_b1 = b1;
    cycle();
    coef_load = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 60 && (exp_q.size() != 0 || pending); i++) cycle();
    check("drain_timeout", 128'(exp_q.size()), 0);
    cycle();
  endtask

  // Single sample into an empty pipeline: exact latency and value.
  task automatic send_check(input string tag, input logic [X_W-1:0] x, input logic [X_W-1:0] y,
                            input logic signed [OUT_W-1:0] ey, input logic es);
    in_valid = 1'b1; in_x = x; in_y_s = y;
    cycle();
    check({tag, "_accept"}, last_acc, 1);
    in_valid = 1'b0;
    #1 check({tag, "_lat1_valid"}, out_valid, 0);
    cycle();
    #1 check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_y"}, out_y, ey);
    check({tag, "_sat"}, out_sat, es);
    cycle();
  endtask

  logic signed [OUT_W-1:0] t2_exp [3];
  logic [X_W-1:0]          t2_x   [5];
  bit                      bp_pat [4];

  initial begin
    rst = 1'b1; coef_load = 1'b0; coef_b0 = '0; coef_b1 = '0;
    in_valid = 1'b0; in_x = '0; in_y_s = '0; out_ready = 1'b1;
    mb0 = '0; mb1 = '0; mcount = 0; masum = '0; pending = 0; have_coef = 0; delivered = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_coef_busy", coef_busy, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(negedge clk);

    // No coefficients yet: samples are refused.
    in_valid = 1'b1; in_x = 20'd9;
    #1 check("empty_in_ready", in_ready, 0);
    cycle();
    in_valid = 1'b0;

    // b0=5, b1=3.0, x=7 -> 26
    load(84'sd5, 56'd3072);
    cycle();
    send_check("t1", 20'd7, 20'd30, 64'sd26, 1'b0);
    check("t1_count", out_count, 1);

    // b0=-10, b1=1.5, x=3,4,5 back-to-back -> -6,-4,-3 on consecutive cycles
    t2_exp[0] = -64'sd6; t2_exp[1] = -64'sd4; t2_exp[2] = -64'sd3;
    t2_x[0] = 20'd3; t2_x[1] = 20'd4; t2_x[2] = 20'd5; t2_x[3] = 20'd0; t2_x[4] = 20'd0;
    load(-84'sd10, 56'd1536);
    cycle();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3); in_x = t2_x[i];
      if (i >= 2) begin
        #1;
        check("t2_valid", out_valid, 1);
        check("t2_y", out_y, t2_exp[i-2]);
      end
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("t2_count", out_count, 3);

    // Saturation at both rails
    load((84'sd1 <<< 63) - 84'sd1, 56'd1024);
    cycle();
    send_check("sat_hi", 20'd1, 20'd0, {1'b0, {(OUT_W-1){1'b1}}}, 1'b1);
    load(-(84'sd1 <<< 70), 56'd1024);
    cycle();
    send_check("sat_lo", 20'd0, 20'd0, {1'b1, {(OUT_W-1){1'b0}}}, 1'b1);

    // Backpressure: 8 samples, out_ready pattern 1,0,0,1
    bp_pat[0] = 1; bp_pat[1] = 0; bp_pat[2] = 0; bp_pat[3] = 1;
    load(84'sd100, 56'd1500);
    cycle();
    begin
      int sent;
      int base;
      sent = 0;
      base = delivered;
      for (int k = 0; k < 100 && (delivered - base) < 8; k++) begin
        in_valid  = (sent < 8);
        in_x      = 20'(sent * 11 + 1);
        out_ready = bp_pat[k % 4];
        cycle();
        if (last_acc) sent++;
      end
      check("bp_delivered", 128'(delivered - base), 8);
    end
    in_valid = 1'b0;
    drain();

    // Coefficient load with two samples in flight; new slope 2.0
    load(84'sd0, 56'd1024);
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 20'd100; cycle();
    in_x = 20'd200; cycle();
    in_valid = 1'b0; cycle();
    in_valid = 1'b1; in_x = 20'd300;
    load(84'sd0, 56'd2048);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("drainA_busy", coef_busy, 1);
      check("drainA_in_ready", in_ready, 0);
      cycle();
    end
    out_ready = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) begin
      #1;
      if (in_ready) check("drainA_count_clear", out_count, 0);
      cycle();
    end
    check("drainA_accepted", last_acc, 1);
    in_valid = 1'b0;
    drain();

    // Second load during DRAIN wins (5.0 replaces 2.0)
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 20'd100; cycle();
    in_x = 20'd200; cycle();
    in_valid = 1'b0;
    load(84'sd0, 56'd2048);
    cycle();
    load(84'sd0, 56'd5120);
    #1 check("drainB_busy", coef_busy, 1);
    out_ready = 1'b1;
    drain();
    send_check("drainB_new", 20'd10, 20'd0, 64'sd50, 1'b0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      coef_load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) coef_b0 = B0_W'({$urandom(), $urandom(), $urandom()});
      else coef_b0 = $signed({{(B0_W-40){1'b0}}, 40'({$urandom(), $urandom()})}) - (84'sd1 <<< 39);
      if ($urandom_range(0, 4) == 0) coef_b1 = B1_W'({$urandom(), $urandom()});
      else coef_b1 = B1_W'($urandom_range(0, 65536));
      in_valid  = $urandom_range(0, 3) != 0;
      in_x      = X_W'($urandom());
      in_y_s    = X_W'($urandom());
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    coef_load = 1'b0;
    drain();

    // Reset with the pipeline full
    load(84'sd5, 56'd3072);
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 20'd1; cycle();
    in_x = 20'd2; cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_coef_busy", coef_busy, 0);
    check("midrst_out_count", out_count, 0);
    exp_q.delete();
    mcount = 0; masum = '0; pending = 0; have_coef = 0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycle();
    load(84'sd5, 56'd3072);
    cycle();
    send_check("post_rst", 20'd7, 20'd30, 64'sd26, 1'b0);
`ifdef LINREG_RESIDUAL_EN
    check("res_abs_sum", out_abs_sum, 4);
`endif
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
